// File: rtl/dmem_bridge.sv
// Data-memory bridge: word-organised RAM behind an IDLE/WAIT/DONE handshake with byte-lane stores.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_bridge #(
  parameter int unsigned DEPTH       = 2048,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] w_data,
  input  logic        dmem_w,
  input  logic        dmem_r,
  input  logic [1:0]  store_format_signal,
  output logic [31:0] dmem_data,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   addr_rel;
  logic [AW-1:0] idx_in;
  logic          unused_addr;
  logic [31:0]   rword, wlane, merged, load_val;
  logic [3:0]    be;
  logic          is_byte, is_half, misalign, commit;

  // Out-of-range addresses wrap onto the RAM by dropping the high index bits.
  assign addr_rel    = data_addr - BASE_ADDR;
  assign idx_in      = addr_rel[AW+1:2];
  assign unused_addr = ^{addr_rel[31:AW+2], addr_rel[1:0]};

  assign is_byte = (size_q == 2'b10);
  assign is_half = (size_q == 2'b01);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = (is_half && off_q[0]) || (!is_byte && !is_half && (off_q != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // A reset landing in DONE suppresses both the completion pulse and the commit.
  assign ready  = (state_q == StDone) && !rst;
  assign err    = ready && misalign;
  assign commit = ready && !misalign;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    write_d = write_q;
    unique case (state_q)
      StIdle: begin
        if (dmem_w || dmem_r) begin
          idx_d   = idx_in;
          off_d   = data_addr[1:0];
          wdata_d = w_data;
          size_d  = store_format_signal;
          write_d = dmem_w;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end else begin
            state_d = StDone;
          end
        end
      end
      StWait: begin
        if (!dmem_w && !dmem_r) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rword    = mem[idx_q];
    be       = 4'b1111;
    wlane    = wdata_q;
    load_val = rword;
    if (is_byte) begin
      be       = 4'b0001 << off_q;
      wlane    = {4{wdata_q[7:0]}};
      load_val = {24'b0, rword[{off_q, 3'b000} +: 8]};
    end else if (is_half) begin
      be       = off_q[1] ? 4'b1100 : 4'b0011;
      wlane    = {2{wdata_q[15:0]}};
      load_val = {16'b0, rword[{off_q[1], 4'b0000} +: 16]};
    end
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wlane[8*i +: 8] : rword[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      write_q <= write_d;
      if (commit && !write_q) begin
        rdata_q <= load_val;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && write_q) begin
      mem[idx_q] <= merged;
    end
  end

  assign dmem_data = rdata_q;

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory stage directly downstream of the multi-cycle CPU core. Accepts the core's byte address, store data, read/write strobes and access-size code; performs word, halfword and byte stores with lane merging, and returns loads right-justified so the core's own 8/16-bit extenders consume them unchanged. Holds the word-organised data RAM and sequences every access through a small handshake FSM with configurable wait states.

## Interface
- `DEPTH`, 2048: data RAM size in 32-bit words; power of two.
- `BASE_ADDR`, 32'h1001_0000: byte address mapped to word 0.
- `WAIT_CYCLES`, 0: extra stall cycles per access, 0..15.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data_addr` in 32: byte address from the core.
- `w_data` in 32: store data; the active lane is taken from the low bits.
- `dmem_w` in 1: write request level.
- `dmem_r` in 1: read request level.
- `store_format_signal` in 2: access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- `dmem_data` out 32: load result, right-justified, zero-filled above the lane.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle misaligned-access pulse; exists only with `DMEM_ALIGN_CHECK_EN`, otherwise tied 0.

## Operation
- Word index = ((`data_addr` - `BASE_ADDR`) >> 2) mod `DEPTH`. Out-of-range addresses wrap and are not flagged. Byte offset `off` = `data_addr[1:0]`.
- FSM states are IDLE, WAIT and DONE.
  - IDLE: if `dmem_w` or `dmem_r` is high, latch address, data, size and direction. Go to WAIT if `WAIT_CYCLES`>0, else DONE.
  - WAIT: the counter loads `WAIT_CYCLES` and decrements each cycle. At 1, go to DONE. If both requests drop, abort to IDLE with no RAM change.
  - DONE: `ready`=1 for exactly this cycle. The store commits at the rising edge that ends DONE, or the load result is registered at it. Always return to IDLE.
- If `dmem_w` and `dmem_r` are both high, the access is a write and the read is ignored.
- Stores use the byte lanes addressed by `off`:
  - byte: lane `off` ← `w_data[7:0]`.
  - halfword: lanes `off[1]`*2 and `off[1]`*2+1 ← `w_data[15:0]`.
  - word: all lanes ← `w_data`.
  - Unselected lanes keep their values.
- Loads:
  - byte: `dmem_data` = {24'b0, lane `off`}.
  - halfword: `dmem_data` = {16'b0, halfword `off[1]`}.
  - word: the full word.
  - `dmem_data` holds until the next completed read. Writes do not disturb it.
- The core keeps its request high until it sees `ready`, then drops it. A request still high in the cycle after DONE starts a new access.
- RAM contents are not cleared by `rst`.

## Timing
- Reset values: FSM in IDLE, counter 0, `ready`=0, `err`=0, `dmem_data`=0.
- Latency: a request first sampled in IDLE in cycle t gives `ready` in cycle t+1+`WAIT_CYCLES`. The load data is valid on `dmem_data` from cycle t+2+`WAIT_CYCLES`.
- Throughput: one access per 2+`WAIT_CYCLES` cycles, counting the mandatory IDLE cycle.
- `rst` asserted in WAIT or DONE: the FSM goes to IDLE. No store commits and `ready` stays low.
- Request inputs are sampled only in IDLE. Changes to address or data during WAIT/DONE are ignored because the latched values are used.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- Defined:
  - A halfword access with `off[0]`=1, or a word access with `off`≠0, is misaligned.
  - On a misaligned access the FSM still runs IDLE→(WAIT)→DONE. In DONE, `err`=1 together with `ready`=1.
  - No RAM write occurs, and `dmem_data` keeps its previous value.
- Undefined:
  - Misaligned low address bits are masked: halfword uses `off[1]`, word uses lane 0.
  - The access completes normally. The `err` port is present and tied 0.

## Test plan
- Reset, then word store 0xDEADBEEF to 0x1001_0004, then word load from the same address with `WAIT_CYCLES`=0: `ready` 1 cycle after each request, and the load returns 0xDEADBEEF.
- Byte store 0x5A to 0x1001_0006 over word 0x11223344, then word load: 0x115A3344. Byte load at 0x1001_0006 returns 0x0000005A.
- Halfword store 0xCAFE to 0x1001_0002 over 0x00000000, then halfword load at 0x1001_0002: 0x0000CAFE. Word load returns 0xCAFE0000.
- `WAIT_CYCLES`=3: `ready` rises exactly 4 cycles after the request. Dropping `dmem_w` in the 2nd WAIT cycle aborts the access, leaves the RAM unchanged and gives no `ready`.
- `rst` pulsed in DONE of a store of 0x12345678 to 0x1001_0010: no `ready`, and a later load returns the old value. `dmem_data`=0 immediately after reset.
- With `DMEM_ALIGN_CHECK_EN`, a word store to 0x1001_0001 gives `err`=`ready`=1 and leaves memory unchanged. Without it, the same store writes word 0x1001_0000 and `err` stays 0.
